// File: rtl/fft_peak_detector.sv
// Peak search over the positive-frequency half of a serial FFT bin stream.
// Reports peak bin, L1 magnitude, frequency and a threshold flag at end of frame.
module fft_peak_detector #(
    parameter int           N       = 32,
    parameter int           DW      = 32,
    parameter int           FS_HZ   = 8000,
    parameter logic [DW:0]  THRESH  = '0,
    parameter bit           SKIP_DC = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    frame_start,
    input  logic [DW-1:0]           in_re,
    input  logic [DW-1:0]           in_im,
    output logic                    busy,
    output logic                    res_valid,
    output logic [$clog2(N)-1:0]    peak_bin,
    output logic [DW:0]             peak_mag,
    output logic [31:0]             peak_freq,
    output logic                    detected,
    output logic                    frame_err
);
    localparam int          CW      = $clog2(N);
    localparam int unsigned BIN_HZ  = FS_HZ / N;
    localparam logic [CW-1:0] FIRST   = SKIP_DC ? CW'(1) : '0;
    localparam logic [CW-1:0] HALF_M1 = CW'(N / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);

    // Handshake: in_valid qualifies in_re/in_im/frame_start for one beat; there is
    // no backpressure, every valid beat is accepted, and gaps only stall counting.
    logic [CW-1:0] cnt;
    logic          s0_valid;
    logic [DW-1:0] s0_re, s0_im;
    logic [CW-1:0] s0_bin;
    logic          s1_valid, s1_last;
    logic [DW:0]   s1_mag;
    logic [CW-1:0] s1_bin;
    logic [DW:0]   max_mag;
    logic [CW-1:0] max_bin;

    logic          misalign;
    logic [DW:0]   re_ext, im_ext, abs_re, abs_im, mag;
    logic [DW+1:0] mag_sum;
    logic          in_range, take;
    logic [DW:0]   nxt_mag;
    logic [CW-1:0] nxt_bin;
    logic          frame_done;

    assign misalign = in_valid && frame_start && (cnt != '0);
    assign busy     = (cnt != '0);

    // Sign-extending before negation keeps -2^(DW-1) exact.
    always_comb begin
        re_ext  = {s0_re[DW-1], s0_re};
        im_ext  = {s0_im[DW-1], s0_im};
        abs_re  = re_ext[DW] ? (~re_ext + {{DW{1'b0}}, 1'b1}) : re_ext;
        abs_im  = im_ext[DW] ? (~im_ext + {{DW{1'b0}}, 1'b1}) : im_ext;
        mag_sum = {1'b0, abs_re} + {1'b0, abs_im};
        mag     = mag_sum[DW+1] ? '1 : mag_sum[DW:0];
    end

    always_comb begin
        in_range   = (s1_bin <= HALF_M1) && (SKIP_DC ? (s1_bin != '0) : 1'b1);
        take       = s1_valid && in_range && (s1_mag > max_mag);
        nxt_mag    = take ? s1_mag : max_mag;
        nxt_bin    = take ? s1_bin : max_bin;
        frame_done = s1_valid && s1_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            s0_valid  <= 1'b0;
            s0_re     <= '0;
            s0_im     <= '0;
            s0_bin    <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mag    <= '0;
            s1_bin    <= '0;
            max_mag   <= '0;
            max_bin   <= FIRST;
            res_valid <= 1'b0;
            peak_bin  <= '0;
            peak_mag  <= '0;
            peak_freq <= '0;
            detected  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            frame_err <= misalign;
            s0_valid  <= in_valid;
            if (in_valid) begin
                s0_re  <= in_re;
                s0_im  <= in_im;
                s0_bin <= misalign ? '0 : cnt;
                cnt    <= misalign ? CW'(1) : cnt + CW'(1);
            end
            // A misaligned start kills the aborted bin still sitting in S0.
            s1_valid <= s0_valid && !misalign;
            s1_mag   <= mag;
            s1_bin   <= s0_bin;
            s1_last  <= (s0_bin == LAST);

            if (frame_done) begin
                peak_bin  <= nxt_bin;
                peak_mag  <= nxt_mag;
                peak_freq <= 32'(nxt_bin) * BIN_HZ;
                detected  <= (nxt_mag > THRESH);
                res_valid <= 1'b1;
            end
            // Re-init on frame end and on abort; a previous frame's last beat in S1
            // still reports above before the running max is discarded.
            if (frame_done || misalign) begin
                max_mag <= '0;
                max_bin <= FIRST;
            end else if (s1_valid) begin
                max_mag <= nxt_mag;
                max_bin <= nxt_bin;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Bench for fft_peak_detector: spec vector table, hand sequences for continuous
// frames / misaligned start / mid-frame reset, and random frames against a frame model.
module tb_fft_peak_detector;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, frame_start;
    logic [31:0] in_re, in_im;

    logic        busy, res_valid, detected, frame_err;
    logic [4:0]  peak_bin;
    logic [32:0] peak_mag;
    logic [31:0] peak_freq;
    logic        a_busy, a_res_valid, a_detected, a_frame_err;
    logic [4:0]  a_peak_bin;
    logic [32:0] a_peak_mag;
    logic [31:0] a_peak_freq;

    fft_peak_detector u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .frame_start(frame_start),
        .in_re(in_re), .in_im(in_im), .busy(busy), .res_valid(res_valid),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_freq(peak_freq),
        .detected(detected), .frame_err(frame_err)
    );

    fft_peak_detector #(.THRESH(33'd2000), .SKIP_DC(1'b0)) u_alt (
        .clk(clk), .reset(reset), .in_valid(in_valid), .frame_start(frame_start),
        .in_re(in_re), .in_im(in_im), .busy(a_busy), .res_valid(a_res_valid),
        .peak_bin(a_peak_bin), .peak_mag(a_peak_mag), .peak_freq(a_peak_freq),
        .detected(a_detected), .frame_err(a_frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct packed {
        int          cyc;
        logic [4:0]  bin;
        logic [32:0] mag;
        logic [31:0] freq;
        logic        det;
        logic [4:0]  bin_a;
        logic [32:0] mag_a;
        logic [31:0] freq_a;
        logic        det_a;
    } exp_t;

    exp_t       exp_q[$];
    int         err_q[$];
    int         res_cyc_q[$];
    logic [4:0] res_bin_q[$];
    int         res_count = 0;
    int         err_count = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_re[N], m_im[N];
    int          mcnt = 0;

    function automatic void peak_of(input int first, output int bin, output longint mag);
        longint a, b, m;
        bin = first;
        mag = 0;
        for (int i = first; i < N / 2; i++) begin
            a = longint'($signed(m_re[i]));
            b = longint'($signed(m_im[i]));
            if (a < 0) a = -a;
            if (b < 0) b = -b;
            m = a + b;
            if (m > 64'h1_FFFF_FFFF) m = 64'h1_FFFF_FFFF;
            if (m > mag) begin
                mag = m;
                bin = i;
            end
        end
    endfunction

    task automatic model_beat(input logic v, input logic fs, input logic [31:0] re, input logic [31:0] im);
        int     b, ba;
        longint m, ma;
        exp_t   e;
        if (!v) return;
        if (fs && mcnt != 0) begin
            err_q.push_back(cyc);
            mcnt = 0;
        end
        m_re[mcnt] = re;
        m_im[mcnt] = im;
        mcnt++;
        if (mcnt == N) begin
            mcnt = 0;
            peak_of(1, b, m);
            peak_of(0, ba, ma);
            e.cyc    = cyc + 2;
            e.bin    = 5'(b);
            e.mag    = 33'(m);
            e.freq   = 32'(b * 250);
            e.det    = (m > 0);
            e.bin_a  = 5'(ba);
            e.mag_a  = 33'(ma);
            e.freq_a = 32'(ba * 250);
            e.det_a  = (ma > 2000);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("res_missing_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (err_q.size() > 0 && err_q[0] < cyc) begin
                check("frame_err_missing_cycle", cyc, err_q[0]);
                void'(err_q.pop_front());
            end
            if (res_valid || a_res_valid) begin
                res_count++;
                res_cyc_q.push_back(cyc);
                res_bin_q.push_back(peak_bin);
                if (exp_q.size() == 0) begin
                    check("res_valid_unexpected", res_valid | a_res_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_cycle", cyc, e.cyc);
                    check("res_valid", res_valid, 1);
                    check("peak_bin", peak_bin, e.bin);
                    check("peak_mag", peak_mag, e.mag);
                    check("peak_freq", peak_freq, e.freq);
                    check("detected", detected, e.det);
                    check("alt_res_valid", a_res_valid, 1);
                    check("alt_peak_bin", a_peak_bin, e.bin_a);
                    check("alt_peak_mag", a_peak_mag, e.mag_a);
                    check("alt_peak_freq", a_peak_freq, e.freq_a);
                    check("alt_detected", a_detected, e.det_a);
                end
            end
            if (frame_err || a_frame_err) begin
                err_count++;
                if (err_q.size() == 0) begin
                    check("frame_err_unexpected", frame_err | a_frame_err, 0);
                end else begin
                    check("frame_err_cycle", cyc, err_q.pop_front());
                    check("frame_err_pair", {frame_err, a_frame_err}, 2'b11);
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [31:0] s_re[N], s_im[N];

    task automatic beat(input logic v, input logic fs, input logic [31:0] re, input logic [31:0] im);
        in_valid    = v;
        frame_start = fs;
        in_re       = re;
        in_im       = im;
        @(posedge clk);
        #1;
        model_beat(v, fs, re, im);
        check("busy", busy, (mcnt != 0));
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, '0, '0);
    endtask

    task automatic send_beats(input int count, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            beat(1'b1, (i == 0), s_re[i], s_im[i]);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            s_re[i] = '0;
            s_im[i] = '0;
        end
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        mcnt  = 0;
        exp_q.delete();
        err_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_peak_bin"}, peak_bin, 0);
        check({tag, "_peak_mag"}, peak_mag, 0);
        check({tag, "_peak_freq"}, peak_freq, 0);
        check({tag, "_detected"}, detected, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0: rnd_val = '0;
            1: rnd_val = 32'(int'($urandom_range(0, 8)) - 4);
            2: rnd_val = $urandom;
            default: rnd_val = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int     b0; int re0; int im0;
        int     b1; int re1; int im1;
        int     b2; int re2; int im2;
        int     e_bin;
        longint e_mag;
        int     e_freq;
        int     e_det;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rc, ec, nres, p;

        tbl[0] = '{5, 1000, -300, -1, 0, 0, -1, 0, 0, 5, 64'd1300, 1250, 1};
        tbl[1] = '{0, 100000, 0, 3, 50, 0, 29, 9999, 0, 3, 64'd50, 750, 1};
        tbl[2] = '{4, 0, -500, 7, 0, -500, -1, 0, 0, 4, 64'd500, 1000, 1};
        tbl[3] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 1, 64'd0, 250, 0};
        tbl[4] = '{2, 'h8000_0000, 0, -1, 0, 0, -1, 0, 0, 2, 64'd2147483648, 500, 1};
        tbl[5] = '{15, -7, 8, 16, 1000, 1000, -1, 0, 0, 15, 64'd15, 3750, 1};
        tbl[6] = '{1, 'h8000_0000, 'h8000_0000, 31, 5, 5, -1, 0, 0, 1, 64'h1_0000_0000, 250, 1};

        reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Table vectors, continuous in_valid within each frame.
        for (int i = 0; i < 7; i++) begin
            clear_stim();
            if (tbl[i].b0 >= 0) begin s_re[tbl[i].b0] = tbl[i].re0; s_im[tbl[i].b0] = tbl[i].im0; end
            if (tbl[i].b1 >= 0) begin s_re[tbl[i].b1] = tbl[i].re1; s_im[tbl[i].b1] = tbl[i].im1; end
            if (tbl[i].b2 >= 0) begin s_re[tbl[i].b2] = tbl[i].re2; s_im[tbl[i].b2] = tbl[i].im2; end
            rc = res_count;
            send_beats(N, 0);
            idle(3);
            check($sformatf("tbl%0d_count", i), res_count, rc + 1);
            check($sformatf("tbl%0d_bin", i), peak_bin, tbl[i].e_bin);
            check($sformatf("tbl%0d_mag", i), peak_mag, tbl[i].e_mag);
            check($sformatf("tbl%0d_freq", i), peak_freq, tbl[i].e_freq);
            check($sformatf("tbl%0d_det", i), detected, tbl[i].e_det);
            if (i == 0) check("tbl0_thresh2000_det", a_detected, 0);
        end

        // Two back-to-back frames: results exactly one frame apart.
        nres = res_cyc_q.size();
        clear_stim(); s_re[6] = 77;
        send_beats(N, 0);
        clear_stim(); s_im[9] = 88;
        send_beats(N, 0);
        idle(3);
        check("b2b_count", res_cyc_q.size(), nres + 2);
        if (res_cyc_q.size() >= nres + 2) begin
            check("b2b_spacing", res_cyc_q[nres + 1] - res_cyc_q[nres], 32);
            check("b2b_first_bin", res_bin_q[nres], 6);
            check("b2b_second_bin", res_bin_q[nres + 1], 9);
        end

        // Misaligned frame_start at beat 10.
        rc = res_count;
        ec = err_count;
        clear_stim(); s_re[3] = 5000; s_im[3] = 5000;
        send_beats(10, 0);
        clear_stim(); s_re[8] = 32'(-123); s_im[8] = 4;
        send_beats(N, 0);
        idle(3);
        check("abort_err_count", err_count, ec + 1);
        check("abort_res_count", res_count, rc + 1);
        check("abort_bin", peak_bin, 8);
        check("abort_mag", peak_mag, 127);

        // Reset at beat 20 drops the partial frame and clears outputs.
        rc = res_count;
        clear_stim(); s_re[12] = 4444;
        send_beats(20, 0);
        do_reset(2);
        idle(5);
        check("midreset_res_count", res_count, rc);
        check_outputs_zero("midreset");

        // Random frames with gaps and occasional aborts.
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) begin s_re[i] = rnd_val(); s_im[i] = rnd_val(); end
                p = $urandom_range(1, 31);
                send_beats(p, 20);
            end
            for (int i = 0; i < N; i++) begin s_re[i] = rnd_val(); s_im[i] = rnd_val(); end
            send_beats(N, $urandom_range(0, 1) ? 15 : 0);
        end
        idle(5);
        check("exp_q_empty", exp_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
